// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the per-core memory port: bus widths, FSM encoding
// and the queued request record.
package gpu_mem_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned BANK_W  = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned N_CORES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // addr[11:8] selects the bank; the arbiters decode it, this port only forwards it
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/core_mem_port_if.sv
// Core-side request/response handshake plus this core's slice of the bank
// arbiter bus.
interface core_mem_port_if;
  import gpu_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_finish;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_finish, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_finish, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO; one extra pointer bit distinguishes full from empty.
module mem_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[PTR_W-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/core_mem_port.sv
// Per-core memory port: queues core requests, issues them one at a time to the
// bank arbiters, and returns a response (or timeout error) in order.
module core_mem_port
  import gpu_mem_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic            clock,
  input  logic            reset,
  core_mem_port_if.slave  bus
);

  state_t            state;
  state_t            state_next;
  mem_req_t          incoming;
  mem_req_t          head;
  mem_req_t          issue;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [7:0]        wait_cnt;
  logic              timeout_hit;
  logic [DATA_W-1:0] rdata;
  logic              err;

  assign incoming    = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
  assign push        = bus.req_valid && !fifo_full;
  assign pop         = (state == IDLE) && !fifo_empty;
  assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));
  assign bus.req_ready = !fifo_full;

  mem_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(mem_req_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (incoming),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = ISSUE;
      ISSUE:   if (bus.mem_finish || timeout_hit) state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Finish is tested before timeout so a same-cycle finish completes cleanly.
  always_ff @(posedge clock) begin
    if (reset) begin
      issue    <= '0;
      wait_cnt <= '0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (pop) issue <= head;
        end
        ISSUE: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (bus.mem_finish) begin
            rdata <= issue.we ? '0 : bus.mem_rdata;
            err   <= 1'b0;
          end else if (timeout_hit) begin
            rdata <= '0;
            err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    case (state)
      ISSUE: begin
        bus.mem_read  = !issue.we;
        bus.mem_write = issue.we;
        bus.mem_addr  = issue.addr;
        bus.mem_wdata = issue.wdata;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata;
        bus.resp_err   = err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_mem_port.sv
// Directed bench for core_mem_port: reads, writes, queue back-pressure,
// timeout, spurious finish and mid-issue reset.
module tb_core_mem_port;

  logic clock = 1'b0;
  logic reset = 1'b1;

  core_mem_port_if bus ();

  core_mem_port #(
    .FIFO_DEPTH (2),
    .TIMEOUT    (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic push_one(input logic we, input logic [11:0] addr, input logic [7:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Waits for the strobe, checks the issued fields for delay+1 cycles, then
  // answers with finish and consumes the response after hold stall cycles.
  task automatic serve(input string tag, input logic [11:0] addr, input logic we,
                       input logic [7:0] wdata, input logic [7:0] mrdata,
                       input int unsigned delay, input int unsigned hold);
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.mem_read || bus.mem_write) found = 1'b1;
      else tick();
    end
    check({tag, "_issue"}, found, 1);
    for (int unsigned d = 0; d <= delay; d++) begin
      check({tag, "_addr"},  bus.mem_addr,  addr);
      check({tag, "_read"},  bus.mem_read,  !we);
      check({tag, "_write"}, bus.mem_write, we);
      check({tag, "_wdata"}, bus.mem_wdata, wdata);
      if (d < delay) tick();
    end
    bus.mem_finish = 1'b1;
    bus.mem_rdata  = mrdata;
    tick();
    bus.mem_finish = 1'b0;
    bus.mem_rdata  = 8'hEE;
    check({tag, "_strobe_off"}, {bus.mem_read, bus.mem_write}, 0);
    check({tag, "_resp_valid"}, bus.resp_valid, 1);
    check({tag, "_resp_rdata"}, bus.resp_rdata, we ? 8'h00 : mrdata);
    check({tag, "_resp_err"},   bus.resp_err,   0);
    repeat (hold) begin
      tick();
      check({tag, "_hold_valid"}, bus.resp_valid, 1);
      check({tag, "_hold_rdata"}, bus.resp_rdata, we ? 8'h00 : mrdata);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, "_resp_done"}, bus.resp_valid, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"},  bus.req_ready,  1);
    check({tag, "_resp_valid"}, bus.resp_valid, 0);
    check({tag, "_resp_rdata"}, bus.resp_rdata, 0);
    check({tag, "_resp_err"},   bus.resp_err,   0);
    check({tag, "_mem_read"},   bus.mem_read,   0);
    check({tag, "_mem_write"},  bus.mem_write,  0);
    check({tag, "_mem_addr"},   bus.mem_addr,   0);
    check({tag, "_mem_wdata"},  bus.mem_wdata,  0);
  endtask

  initial begin
    int unsigned n;
    bit found;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    bus.mem_finish = 1'b0;
    bus.mem_rdata  = '0;

    // Reset values, during and after reset
    repeat (2) tick();
    check_quiet("rst_in");
    reset = 1'b0;
    tick();
    check_quiet("rst_out");

    // Read 0x3A5, finish two cycles after the strobe rises
    push_one(1'b0, 12'h3A5, 8'h00);
    check("rd_idle_pop_cycle", bus.mem_read, 0);
    tick();
    serve("rd", 12'h3A5, 1'b0, 8'h00, 8'h5C, 2, 1);

    // Write 0x012 / 0xFF; read data on the bus must not leak into the response
    push_one(1'b1, 12'h012, 8'hFF);
    serve("wr", 12'h012, 1'b1, 8'hFF, 8'hAA, 3, 0);

    // Three back-to-back reads with the response stalled
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_wdata = 8'h00;
    bus.req_addr  = 12'h100;
    tick();
    bus.req_addr  = 12'hF22;
    check("b2b_ready_1", bus.req_ready, 1);
    tick();
    bus.req_addr  = 12'h7FF;
    check("b2b_ready_2", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    check("b2b_full", bus.req_ready, 0);
    serve("b2b_a", 12'h100, 1'b0, 8'h00, 8'h11, 0, 2);
    check("b2b_still_full", bus.req_ready, 0);
    serve("b2b_b", 12'hF22, 1'b0, 8'h00, 8'h22, 1, 0);
    check("b2b_drain_ready", bus.req_ready, 1);
    serve("b2b_c", 12'h7FF, 1'b0, 8'h00, 8'h33, 0, 0);
    repeat (2) tick();
    check("b2b_no_extra", bus.resp_valid, 0);

    // No finish: strobe for exactly TIMEOUT cycles, then error response
    bus.mem_rdata = 8'h77;
    push_one(1'b0, 12'h5A0, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.mem_read) found = 1'b1;
      else tick();
    end
    check("to_issue", found, 1);
    n = 0;
    while (bus.mem_read && n < 20) begin
      n++;
      tick();
    end
    check("to_issue_cycles", n, 8);
    check("to_resp_valid", bus.resp_valid, 1);
    check("to_resp_err",   bus.resp_err,   1);
    check("to_resp_rdata", bus.resp_rdata, 0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("to_resp_done", bus.resp_valid, 0);

    // Finish on the last allowed cycle wins over the timeout
    push_one(1'b0, 12'h9C3, 8'h00);
    serve("tie", 12'h9C3, 1'b0, 8'h00, 8'hA7, 7, 0);

    // Finish pulsed while idle is ignored
    bus.mem_finish = 1'b1;
    bus.mem_rdata  = 8'h33;
    tick();
    bus.mem_finish = 1'b0;
    repeat (2) tick();
    check_quiet("idle_fin");
    push_one(1'b1, 12'hC34, 8'h5A);
    serve("idle_fin_after", 12'hC34, 1'b1, 8'h5A, 8'h44, 1, 0);

    // Reset in the second ISSUE cycle with one request queued
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_wdata = 8'h00;
    bus.req_addr  = 12'h8C4;
    tick();
    bus.req_addr  = 12'h2B1;
    tick();
    bus.req_valid = 1'b0;
    check("mr_issue1", bus.mem_read, 1);
    check("mr_addr",   bus.mem_addr, 12'h8C4);
    tick();
    check("mr_issue2", bus.mem_read, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_strobe_off", bus.mem_read, 0);
    check("mr_ready",      bus.req_ready, 1);
    check("mr_no_resp",    bus.resp_valid, 0);
    repeat (5) begin
      tick();
      check("mr_quiet_resp", bus.resp_valid, 0);
      check("mr_quiet_read", bus.mem_read, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
